// File: rtl/fetch_ir_unit.sv
// PC, instruction register, memory data register and retired-instruction counter for the multi-cycle CPU.
// Optional macro PC_ALIGN_CHECK_EN: refuse misaligned next-PC values and raise a sticky MisalignErr.
module fetch_ir_unit #(
  parameter logic [31:0] PC_RESET    = 32'h0040_0000,
  parameter int          COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   PCWrite,
  input  logic                   PCWriteCond,
  input  logic                   Zero,
  input  logic [1:0]             PCSource,
  input  logic [31:0]            ALUResult,
  input  logic [31:0]            ALUOut,
  input  logic [31:0]            RegA,
  input  logic [31:0]            MemData,
  input  logic                   MemRead,
  input  logic                   IRWrite,
  input  logic                   ExtOp,
  input  logic                   LuiOp,
  output logic [31:0]            PC,
  output logic [31:0]            Instruction,
  output logic [5:0]             OpCode,
  output logic [5:0]             Funct,
  output logic [4:0]             Rs,
  output logic [4:0]             Rt,
  output logic [4:0]             Rd,
  output logic [4:0]             Shamt,
  output logic [31:0]            ImmExt,
  output logic [31:0]            JumpTarget,
  output logic [31:0]            MDR,
  output logic [COUNT_WIDTH-1:0] InstCount,
  output logic                   IRValid
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic                   MisalignErr
`endif
);

  logic [31:0] next_pc;
  logic        pc_en;
  logic        pc_load;

  assign OpCode     = Instruction[31:26];
  assign Rs         = Instruction[25:21];
  assign Rt         = Instruction[20:16];
  assign Rd         = Instruction[15:11];
  assign Shamt      = Instruction[10:6];
  assign Funct      = Instruction[5:0];
  assign JumpTarget = {PC[31:28], Instruction[25:0], 2'b00};

  always_comb begin
    ImmExt = {16'h0000, Instruction[15:0]};
    if (LuiOp)
      ImmExt = {Instruction[15:0], 16'h0000};
    else if (ExtOp)
      ImmExt = {{16{Instruction[15]}}, Instruction[15:0]};
  end

  always_comb begin
    next_pc = ALUResult;
    case (PCSource)
      2'b00: next_pc = ALUResult;
      2'b01: next_pc = ALUOut;
      2'b10: next_pc = RegA;
      2'b11: next_pc = JumpTarget;
      default: next_pc = ALUResult;
    endcase
  end

  assign pc_en = PCWrite | (PCWriteCond & Zero);

`ifdef PC_ALIGN_CHECK_EN
  assign pc_load = pc_en & (next_pc[1:0] == 2'b00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      MisalignErr <= 1'b0;
    else if (pc_en && (next_pc[1:0] != 2'b00))
      MisalignErr <= 1'b1;
  end
`else
  assign pc_load = pc_en;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      PC <= PC_RESET;
    else if (pc_load)
      PC <= next_pc;
  end

  // The counter tallies load strobes, so a held IRWrite counts every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Instruction <= 32'h0000_0000;
      InstCount   <= '0;
      IRValid     <= 1'b0;
    end else if (IRWrite) begin
      Instruction <= MemData;
      InstCount   <= InstCount + COUNT_WIDTH'(1);
      IRValid     <= 1'b1;
    end
  end

  // A fetch must not overwrite data brought in by an earlier load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      MDR <= 32'h0000_0000;
    else if (MemRead && !IRWrite)
      MDR <= MemData;
  end

endmodule

// File: tb/tb_fetch_ir_unit.sv
// Directed self-checking bench for fetch_ir_unit, built with a 4-bit instruction counter to reach wrap quickly.
module tb_fetch_ir_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCWrite, PCWriteCond, Zero, MemRead, IRWrite, ExtOp, LuiOp;
  logic [1:0]  PCSource;
  logic [31:0] ALUResult, ALUOut, RegA, MemData;
  logic [31:0] PC, Instruction, ImmExt, JumpTarget, MDR;
  logic [5:0]  OpCode, Funct;
  logic [4:0]  Rs, Rt, Rd, Shamt;
  logic [3:0]  InstCount;
  logic        IRValid;
`ifdef PC_ALIGN_CHECK_EN
  logic        MisalignErr;
`endif

  int vector_count = 0;
  int miss_count   = 0;

  fetch_ir_unit #(.PC_RESET(32'h0040_0000), .COUNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Zero(Zero),
    .PCSource(PCSource), .ALUResult(ALUResult), .ALUOut(ALUOut), .RegA(RegA),
    .MemData(MemData), .MemRead(MemRead), .IRWrite(IRWrite), .ExtOp(ExtOp), .LuiOp(LuiOp),
    .PC(PC), .Instruction(Instruction), .OpCode(OpCode), .Funct(Funct), .Rs(Rs), .Rt(Rt),
    .Rd(Rd), .Shamt(Shamt), .ImmExt(ImmExt), .JumpTarget(JumpTarget), .MDR(MDR),
    .InstCount(InstCount), .IRValid(IRValid)
`ifdef PC_ALIGN_CHECK_EN
    , .MisalignErr(MisalignErr)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vector_count++;
    if (observed !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of control, advance past the edge, then return all strobes to idle.
  task automatic applyStimulus(input logic pcw, input logic pcwc, input logic z, input logic [1:0] src,
                               input logic irw, input logic mrd, input logic [31:0] mdata);
    PCWrite = pcw; PCWriteCond = pcwc; Zero = z; PCSource = src;
    IRWrite = irw; MemRead = mrd; MemData = mdata;
    @(posedge clk);
    #1;
    PCWrite = 1'b0; PCWriteCond = 1'b0; Zero = 1'b0; IRWrite = 1'b0; MemRead = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    PCWrite = 0; PCWriteCond = 0; Zero = 0; MemRead = 0; IRWrite = 0; ExtOp = 0; LuiOp = 0;
    PCSource = 2'b00; ALUResult = 0; ALUOut = 0; RegA = 0; MemData = 0;
    #12 reset = 1'b0;
    #1;
    checkOutput("rst_pc", PC, 32'h0040_0000);
    checkOutput("rst_ir", Instruction, 32'h0);
    checkOutput("rst_cnt", 32'(InstCount), 32'h0);
    checkOutput("rst_valid", 32'(IRValid), 32'h0);
    checkOutput("rst_mdr", MDR, 32'h0);

    // Fetch: PC and IR update together; JumpTarget still reflects the old IR.
    ExtOp = 1'b1;
    ALUResult = 32'h0040_0004;
    PCWrite = 1'b1; IRWrite = 1'b1; MemData = 32'h2008_0005;
    #1 checkOutput("fetch_jt_old", JumpTarget, 32'h0000_0000);
    applyStimulus(1, 0, 0, 2'b00, 1, 0, 32'h2008_0005);
    checkOutput("fetch_pc", PC, 32'h0040_0004);
    checkOutput("fetch_op", 32'(OpCode), 32'h08);
    checkOutput("fetch_rt", 32'(Rt), 32'd8);
    checkOutput("fetch_rs", 32'(Rs), 32'd0);
    checkOutput("fetch_imm", ImmExt, 32'h0000_0005);
    checkOutput("fetch_cnt", 32'(InstCount), 32'd1);
    checkOutput("fetch_valid", 32'(IRValid), 32'd1);

    // Conditional branch
    ALUOut = 32'h0040_0020;
    applyStimulus(0, 1, 0, 2'b01, 0, 0, 32'h0);
    checkOutput("br_nottaken", PC, 32'h0040_0004);
    applyStimulus(0, 1, 1, 2'b01, 0, 0, 32'h0);
    checkOutput("br_taken", PC, 32'h0040_0020);

    // Set up PC=0x00400008 and IR=0x08100010, then jump
    ALUResult = 32'h0040_0008;
    applyStimulus(1, 0, 0, 2'b00, 1, 0, 32'h0810_0010);
    checkOutput("j_setup_pc", PC, 32'h0040_0008);
    checkOutput("j_op", 32'(OpCode), 32'h02);
    checkOutput("j_funct", 32'(Funct), 32'h10);
    checkOutput("j_target", JumpTarget, 32'h0040_0040);
    applyStimulus(1, 0, 0, 2'b11, 0, 0, 32'h0);
    checkOutput("j_pc", PC, 32'h0040_0040);
    RegA = 32'h0040_0100;
    applyStimulus(1, 0, 0, 2'b10, 0, 0, 32'h0);
    checkOutput("jr_pc", PC, 32'h0040_0100);
    ALUResult = 32'h0040_0200;
    applyStimulus(1, 1, 0, 2'b00, 0, 0, 32'h0);
    checkOutput("both_wr_pc", PC, 32'h0040_0200);

    // Immediate extension variants
    applyStimulus(0, 0, 0, 2'b00, 1, 0, 32'h0000_8001);
    ExtOp = 1'b1; LuiOp = 1'b0;
    #1 checkOutput("imm_sext", ImmExt, 32'hFFFF_8001);
    ExtOp = 1'b0;
    #1 checkOutput("imm_zext", ImmExt, 32'h0000_8001);
    ExtOp = 1'b1; LuiOp = 1'b1;
    #1 checkOutput("imm_lui", ImmExt, 32'h8001_0000);
    LuiOp = 1'b0;

    // MDR load, then a fetch that must leave it alone
    applyStimulus(0, 0, 0, 2'b00, 0, 1, 32'hDEAD_BEEF);
    checkOutput("mdr_load", MDR, 32'hDEAD_BEEF);
    applyStimulus(0, 0, 0, 2'b00, 1, 1, 32'h1234_5678);
    checkOutput("mdr_hold", MDR, 32'hDEAD_BEEF);
    checkOutput("mdr_ir", Instruction, 32'h1234_5678);
    checkOutput("cnt_4", 32'(InstCount), 32'd4);

    // Counter wraps after 16 loads
    for (int i = 0; i < 11; i++) applyStimulus(0, 0, 0, 2'b00, 1, 0, 32'h0000_0020 + i);
    checkOutput("cnt_15", 32'(InstCount), 32'd15);
    applyStimulus(0, 0, 0, 2'b00, 1, 0, 32'h0000_0040);
    checkOutput("cnt_wrap", 32'(InstCount), 32'd0);
    checkOutput("valid_sticky", 32'(IRValid), 32'd1);

    // Asynchronous reset mid-cycle
    ALUResult = 32'h0040_0010;
    applyStimulus(1, 0, 0, 2'b00, 0, 0, 32'h0);
    checkOutput("pre_rst_pc", PC, 32'h0040_0010);
    #1 reset = 1'b1;
    #1;
    checkOutput("async_pc", PC, 32'h0040_0000);
    checkOutput("async_ir", Instruction, 32'h0);
    checkOutput("async_cnt", 32'(InstCount), 32'd0);
    checkOutput("async_valid", 32'(IRValid), 32'd0);
    checkOutput("async_mdr", MDR, 32'h0);
    PCWrite = 1'b1; IRWrite = 1'b1; MemRead = 1'b1; MemData = 32'hFFFF_FFFF;
    @(negedge clk);
    @(negedge clk);
    PCWrite = 1'b0; IRWrite = 1'b0; MemRead = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("post_rst_pc", PC, 32'h0040_0000);
    checkOutput("post_rst_ir", Instruction, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule

// File: doc/fetch_ir_unit.md
Name: fetch_ir_unit

Overview:
Holds the program counter, instruction register and memory data register for the multi-cycle CPU, directly upstream of the control FSM. Computes next-PC from the controller's PCWrite/PCWriteCond/PCSource, latches fetched words on IRWrite, and drives the decoded fields (OpCode, Funct, register indices, extended immediate) that the controller and datapath consume. Also keeps a retired-instruction counter for debug.

Parameters:
PC_RESET, 32'h0040_0000, PC value loaded on reset
COUNT_WIDTH, 32, width of InstCount

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
PCWrite  input  1  unconditional PC update
PCWriteCond  input  1  PC update qualified by Zero
Zero  input  1  ALU zero flag (combinational, current cycle)
PCSource  input  2  next-PC select
ALUResult  input  32  combinational ALU output
ALUOut  input  32  registered ALU output (branch target)
RegA  input  32  rs operand register (jr/jalr target)
MemData  input  32  memory read data
MemRead  input  1  memory read strobe
IRWrite  input  1  instruction register load enable
ExtOp  input  1  1 = sign-extend imm16, 0 = zero-extend
LuiOp  input  1  1 = imm16 placed in upper half
PC  output  32  current PC
Instruction  output  32  IR contents
OpCode  output  6  IR[31:26]
Funct  output  6  IR[5:0]
Rs  output  5  IR[25:21]
Rt  output  5  IR[20:16]
Rd  output  5  IR[15:11]
Shamt  output  5  IR[10:6]
ImmExt  output  32  extended immediate
JumpTarget  output  32  {PC[31:28], IR[25:0], 2'b00}
MDR  output  32  memory data register
InstCount  output  COUNT_WIDTH  number of IR loads since reset
IRValid  output  1  set after first IR load

Behaviour:
- Reset (asynchronous, active-high): PC = PC_RESET; IR = 0 (decodes as sll $0,$0,0); MDR = 0; InstCount = 0; IRValid = 0. Reset asserted mid-instruction discards all in-flight state in that cycle; no partial update on the releasing edge.
- Next-PC mux: PCSource 00 -> ALUResult; 01 -> ALUOut; 10 -> RegA; 11 -> JumpTarget (computed from current PC and IR).
- PC load on rising edge when PCWrite | (PCWriteCond & Zero). Both asserted together -> load (OR, no priority conflict). PCWriteCond with Zero=0 -> PC holds.
- IR load: IRWrite=1 -> IR <= MemData on the edge; one-cycle latency, decoded fields valid the cycle after. IRWrite held N cycles -> reloads each cycle, InstCount increments each cycle (counter counts load strobes, not unique instructions).
- IRWrite and PCWrite in the same cycle (fetch): IR takes MemData addressed by the old PC; JumpTarget during that cycle uses the old IR.
- MDR: MemRead=1 and IRWrite=0 -> MDR <= MemData; MemRead with IRWrite -> MDR holds (fetch does not clobber load data).
- InstCount wraps to 0 at 2^COUNT_WIDTH-1 + 1; no saturation, no flag.
- IRValid set on first IR load, cleared only by reset.
- ImmExt (combinational from IR): LuiOp=1 -> {IR[15:0], 16'h0} regardless of ExtOp; else ExtOp=1 -> sign extend; else zero extend.
- All decoded outputs purely combinational from IR; no other latency.

Optional Feature:
PC_ALIGN_CHECK_EN: when defined, a candidate next-PC with bits[1:0] != 00 is not loaded; PC holds and sticky output MisalignErr (1 bit, reset 0) sets, cleared only by reset. When undefined, MisalignErr port absent and any next-PC value is loaded unmodified.

Test Plan:
- Reset release -> PC=32'h0040_0000, Instruction=0, InstCount=0, IRValid=0; assert reset mid-run with PC=32'h0040_0010 -> PC returns to 32'h0040_0000 without waiting for clk.
- Fetch: MemData=32'h2008_0005, IRWrite=1, PCWrite=1, PCSource=00, ALUResult=32'h0040_0004 -> next cycle PC=32'h0040_0004, OpCode=6'h08, Rt=8, ImmExt=32'h0000_0005, InstCount=1, IRValid=1.
- Branch: PCWriteCond=1, PCSource=01, ALUOut=32'h0040_0020, Zero=0 -> PC unchanged; repeat with Zero=1 -> PC=32'h0040_0020.
- Jump: PC=32'h0040_0008, IR=32'h0810_0010, PCWrite=1, PCSource=11 -> PC=32'h0040_0040; jr: PCSource=10, RegA=32'h0040_0100 -> PC=32'h0040_0100.
- Immediate: IR imm16=16'h8001 -> ExtOp=1 gives 32'hFFFF_8001, ExtOp=0 gives 32'h0000_8001, LuiOp=1 gives 32'h8001_0000.
- MDR/counter: MemRead=1, IRWrite=0, MemData=32'hDEAD_BEEF -> MDR=32'hDEAD_BEEF; MemRead=1, IRWrite=1 -> MDR holds; with COUNT_WIDTH=4, 16 IR loads -> InstCount=0.
